// File: rtl/tuple_serializer_if.sv
// tuple_serializer_if: tuple input channel and serial beat output channel
interface tuple_serializer_if;
  logic I_x;
  logic I_y;
  logic I_valid;
  logic I_ready;
  logic O;
  logic O_valid;
  logic O_ready;
  logic O_last;
  modport slave (
    input  I_x, I_y, I_valid, O_ready,
    output I_ready, O, O_valid, O_last
  );
  modport master (
    output I_x, I_y, I_valid, O_ready,
    input  I_ready, O, O_valid, O_last
  );
endinterface

// File: rtl/tuple_serializer.sv
// tuple_serializer: 2-entry tuple FIFO sent as serial beats x, y (plus x^y when TUPLE_SERIALIZER_PARITY_EN is defined)
module tuple_serializer (
  input logic           CLK,
  input logic           RESET,
  tuple_serializer_if.slave bus
);
`ifdef TUPLE_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {BEAT_X, BEAT_Y, BEAT_P} beat_t;
`else
  typedef enum logic {BEAT_X, BEAT_Y} beat_t;
`endif
  beat_t      state, state_nxt;
  logic [1:0] mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count;
  logic [1:0] head;
  logic       i_ready, o_valid, push, fire, last, pop, o_bit;
  assign head    = mem[rd_ptr];
  assign i_ready = (count < 2'd2) && !RESET;
  assign o_valid = (count != 2'd0) && !RESET;
  assign push    = bus.I_valid && i_ready;
  assign fire    = o_valid && bus.O_ready;
  assign pop     = fire && last;
`ifdef TUPLE_SERIALIZER_PARITY_EN
  assign last  = state == BEAT_P;
  assign o_bit = state == BEAT_X ? head[1] : state == BEAT_Y ? head[0] : ^head;
  always_comb begin
    state_nxt = state;
    if (fire)
      state_nxt = state == BEAT_X ? BEAT_Y : state == BEAT_Y ? BEAT_P : BEAT_X;
  end
`else
  assign last  = state == BEAT_Y;
  assign o_bit = state == BEAT_X ? head[1] : head[0];
  always_comb begin
    state_nxt = state;
    if (fire)
      state_nxt = state == BEAT_X ? BEAT_Y : BEAT_X;
  end
`endif
  assign bus.I_ready = i_ready;
  assign bus.O_valid = o_valid;
  assign bus.O       = o_valid && o_bit;
  assign bus.O_last  = o_valid && last;
  // payload storage needs no reset; count gates every read
  always_ff @(posedge CLK)
    if (push) mem[wr_ptr] <= {bus.I_x, bus.I_y};
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= BEAT_X;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      count  <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_tuple_serializer.sv
// tb_tuple_serializer: directed plus random checks against an expected-beat-queue model
module tb_tuple_serializer;
`ifdef TUPLE_SERIALIZER_PARITY_EN
  localparam int FL = 3;
`else
  localparam int FL = 2;
`endif
  typedef struct {logic v; logic l;} beat_s;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int checks = 0;
  int errors = 0;
  beat_s q[$];
  logic obs_beats[$];
  logic want_stream[$];
  bit record = 1'b0;
  tuple_serializer_if bus();
  tuple_serializer dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask
  task automatic check_n(input string tag, input int obs, input int want);
    checks++;
    assert (obs == want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask
  // every accepted tuple contributes one frame of beats; FIFO occupancy is the number of unfinished frames
  task automatic cycle(input logic r, input logic v, input logic x, input logic y,
                       input logic ordy, output bit accepted);
    bit want_ir, want_ov, push, fire;
    logic want_o, want_l;
    int cnt;
    RESET = r;
    bus.I_valid = v;
    bus.I_x = x;
    bus.I_y = y;
    bus.O_ready = ordy;
    @(negedge CLK);
    cnt = (q.size() + FL - 1) / FL;
    want_ir = !r && cnt < 2;
    want_ov = !r && q.size() != 0;
    want_o = want_ov ? q[0].v : 1'b0;
    want_l = want_ov ? q[0].l : 1'b0;
    check("I_ready", bus.I_ready, want_ir);
    check("O_valid", bus.O_valid, want_ov);
    check("O", bus.O, want_o);
    check("O_last", bus.O_last, want_l);
    push = v && want_ir;
    fire = want_ov && ordy;
    if (record && bus.O_valid && ordy) obs_beats.push_back(bus.O);
    accepted = push;
    @(posedge CLK);
    if (r) q.delete();
    else begin
      if (fire) void'(q.pop_front());
      if (push) begin
        q.push_back('{x, 1'b0});
        q.push_back('{y, FL == 2});
        if (FL == 3) q.push_back('{x ^ y, 1'b1});
      end
    end
    #1;
  endtask
  task automatic offer(input logic x, input logic y, input logic ordy);
    bit acc;
    int n = 0;
    do begin
      cycle(1'b0, 1'b1, x, y, ordy, acc);
      n++;
    end while (!acc && n < 20);
    check("offer_accepted", acc, 1'b1);
  endtask
  initial begin
    bit acc;
    bus.I_valid = 1'b0;
    bus.I_x = 1'b0;
    bus.I_y = 1'b0;
    bus.O_ready = 1'b0;
    #1;
    repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, acc);
    // single tuple
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, acc);
    repeat (FL + 2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    // fill under backpressure, third offer refused
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, acc);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, acc);
    check("third_refused", acc, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    repeat (2 * FL + 2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    // stall mid-frame for 5 cycles
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    repeat (FL + 1) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    // streaming
    record = 1'b1;
    offer(1'b0, 1'b0, 1'b1);
    offer(1'b1, 1'b0, 1'b1);
    offer(1'b0, 1'b1, 1'b1);
    offer(1'b1, 1'b1, 1'b1);
    repeat (4 * FL + 2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    record = 1'b0;
    if (FL == 3) want_stream = '{0,0,0, 1,0,1, 0,1,1, 1,1,0};
    else want_stream = '{0,0, 1,0, 0,1, 1,1};
    check_n("stream_len", obs_beats.size(), want_stream.size());
    for (int i = 0; i < want_stream.size() && i < obs_beats.size(); i++)
      check("stream_beat", obs_beats[i], want_stream[i]);
    // reset during BEAT_Y with two tuples stored
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, acc);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, acc);
    repeat (FL + 1) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    // random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), acc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
